// File: rtl/seg_scan_mux_if.sv
// Bundle for the seg_scan_mux digit write port and display drive outputs.
// The master side writes digit registers; the slave side (the driver) owns the display outputs.
interface seg_scan_mux_if #(
  parameter int DIGITS = 8
);
  localparam int AW = $clog2(DIGITS);

  logic              WR_EN;
  logic [AW-1:0]     WR_ADDR;
  logic [4:0]        WR_DATA;
  logic              a, b, c, d, e, f, g;
  logic [DIGITS-1:0] COM;
  logic [AW-1:0]     SCAN_IDX;

  modport master (
    output WR_EN, WR_ADDR, WR_DATA,
    input  a, b, c, d, e, f, g, COM, SCAN_IDX
  );

  modport slave (
    input  WR_EN, WR_ADDR, WR_DATA,
    output a, b, c, d, e, f, g, COM, SCAN_IDX
  );
endinterface

// File: rtl/seg_scan_mux.sv
// Multiplexed N-digit hex 7-segment driver: per-digit {blank,hex} registers, scanned over an active-low COM bus.
// Optional leading-zero blanking is compiled in when SEG_LZB_EN is defined.
module seg_scan_mux #(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 1000
) (
  input logic           CLK,
  input logic           RST,
  seg_scan_mux_if.slave bus
);
  localparam int         AW    = $clog2(DIGITS);
  localparam int         PW    = $clog2(SCAN_DIV);
  localparam logic [4:0] BLANK = 5'b10000;

  logic [4:0]        ent_q [DIGITS];
  logic [PW-1:0]     presc_q, presc_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [6:0]        seg_q, seg_d;
  logic [DIGITS-1:0] com_q, com_d;
  logic [4:0]        cur_ent;
  logic              cur_dark;
  logic              term;
  logic              wr_ok;

  function automatic logic [6:0] hex2seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0:    s = 7'b1111110;
      4'h1:    s = 7'b0110000;
      4'h2:    s = 7'b1101101;
      4'h3:    s = 7'b1111001;
      4'h4:    s = 7'b0110011;
      4'h5:    s = 7'b1011011;
      4'h6:    s = 7'b1011111;
      4'h7:    s = 7'b1110000;
      4'h8:    s = 7'b1111111;
      4'h9:    s = 7'b1111011;
      4'hA:    s = 7'b1110111;
      4'hB:    s = 7'b0011111;
      4'hC:    s = 7'b1001110;
      4'hD:    s = 7'b0111101;
      4'hE:    s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    return s;
  endfunction

  assign wr_ok = bus.WR_EN && ({1'b0, bus.WR_ADDR} < (AW + 1)'(DIGITS));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DIGITS; i++) ent_q[i] <= BLANK;
    end else if (wr_ok) begin
      ent_q[bus.WR_ADDR] <= bus.WR_DATA;
    end
  end

  assign term = (presc_q == PW'(SCAN_DIV - 1));

  always_comb begin
    presc_d = term ? '0 : presc_q + 1'b1;
    idx_d   = idx_q;
    if (term) idx_d = (idx_q == AW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
  end

  assign cur_ent = ent_q[idx_q];

`ifdef SEG_LZB_EN
  // A zero is suppressed while every more-significant digit is zero or blank; digit 0 always shows.
  logic [DIGITS-1:0] sup;
  always_comb begin : lzb_scan
    logic hi_zero;
    hi_zero = 1'b1;
    sup     = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      sup[i]  = hi_zero && (ent_q[i][3:0] == 4'h0);
      hi_zero = hi_zero && (ent_q[i][4] || (ent_q[i][3:0] == 4'h0));
    end
  end
  assign cur_dark = cur_ent[4] | sup[idx_q];
`else
  assign cur_dark = cur_ent[4];
`endif

  // Slot cycle 0 is a dead cycle; a dark digit never pulls its COM line low.
  always_comb begin
    seg_d = '0;
    com_d = '1;
    if ((presc_q != '0) && !cur_dark) seg_d = hex2seg(cur_ent[3:0]);
    if (seg_d != '0) com_d[idx_q] = 1'b0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      presc_q <= '0;
      idx_q   <= '0;
      seg_q   <= '0;
      com_q   <= '1;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      com_q   <= com_d;
    end
  end

  assign {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g} = seg_q;
  assign bus.COM      = com_q;
  assign bus.SCAN_IDX = idx_q;
endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux: an 8-digit, SCAN_DIV=4 instance checked against a queue-based
// reference model, plus a 6-digit instance used for out-of-range write addresses.
module tb_seg_scan_mux;
  localparam int ND = 8;
  localparam int SD = 4;

  typedef struct packed {
    logic [6:0] seg;
    logic [7:0] com;
    logic [2:0] idx;
  } obs_t;

  localparam logic [6:0] DEC [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  logic clk = 1'b0;
  logic rst = 1'b0;

  seg_scan_mux_if #(.DIGITS(8)) bus1 ();
  seg_scan_mux_if #(.DIGITS(6)) bus2 ();

  seg_scan_mux #(.DIGITS(8), .SCAN_DIV(SD)) dut1 (.CLK(clk), .RST(rst), .bus(bus1));
  seg_scan_mux #(.DIGITS(6), .SCAN_DIV(SD)) dut2 (.CLK(clk), .RST(rst), .bus(bus2));

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  logic [4:0] m_ent [ND];
  obs_t       sb [$];

  function automatic obs_t model(input int c);
    obs_t       o;
    int         p, ix;
    logic [4:0] e;
    bit         dark;
    p     = c % SD;
    ix    = (c / SD) % ND;
    o.seg = '0;
    o.com = 8'hFF;
    o.idx = 3'(((c + 1) / SD) % ND);
    e     = m_ent[ix];
    dark  = e[4];
`ifdef SEG_LZB_EN
    if (ix >= 1 && e[3:0] == 4'h0) begin
      bit hz;
      hz = 1'b1;
      for (int j = ix + 1; j < ND; j++)
        if (!(m_ent[j][4] || m_ent[j][3:0] == 4'h0)) hz = 1'b0;
      if (hz) dark = 1'b1;
    end
`endif
    if (p != 0 && !dark) o.seg = DEC[e[3:0]];
    if (o.seg != '0) o.com[ix] = 1'b0;
    return o;
  endfunction

  function automatic obs_t sample1();
    obs_t o;
    o.seg = {bus1.a, bus1.b, bus1.c, bus1.d, bus1.e, bus1.f, bus1.g};
    o.com = bus1.COM;
    o.idx = bus1.SCAN_IDX;
    return o;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    n_tests++;
    assert (got === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, got, exp_v, cyc);
    end
  endtask

  task automatic step(input bit we, input int addr, input logic [4:0] data);
    obs_t got, exp_v;
    sb.push_back(model(cyc));
    bus1.WR_EN   = we;
    bus1.WR_ADDR = 3'(addr);
    bus1.WR_DATA = data;
    if (we && addr < ND) m_ent[addr] = data;
    @(posedge clk);
    #1;
    cyc++;
    bus1.WR_EN = 1'b0;
    got   = sample1();
    exp_v = sb.pop_front();
    check("scan", 32'(got), 32'(exp_v));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 5'h00);
  endtask

  task automatic do_reset();
    obs_t got;
    rst = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    got = sample1();
    check("reset_dut1", 32'(got), 32'({7'b0, 8'hFF, 3'd0}));
    check("reset_dut2", 32'({bus2.a, bus2.g, bus2.COM, bus2.SCAN_IDX}), 32'({2'b0, 6'h3F, 3'd0}));
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    sb.delete();
    for (int i = 0; i < ND; i++) m_ent[i] = 5'b10000;
  endtask

  initial begin
    bus1.WR_EN = 1'b0; bus1.WR_ADDR = '0; bus1.WR_DATA = '0;
    bus2.WR_EN = 1'b0; bus2.WR_ADDR = '0; bus2.WR_DATA = '0;

    do_reset();
    idle(34);

    // Scan order: digits 0..7 hold 0..7, then a full frame plus wrap.
    for (int i = 0; i < ND; i++) step(1'b1, i, 5'(i));
    idle(40);

    // Blanked digit 2.
    step(1'b1, 2, 5'b10111);
    idle(32);

    // Two writes to digit 5 inside its drive window.
    while (cyc % 32 != 21) idle(1);
    step(1'b1, 5, 5'h08);
    step(1'b1, 5, 5'h0F);
    check("wr_slot_8", 32'({bus1.a, bus1.b, bus1.c, bus1.d, bus1.e, bus1.f, bus1.g}), 32'(7'b1111111));
    idle(1);
    check("wr_slot_F", 32'({bus1.a, bus1.b, bus1.c, bus1.d, bus1.e, bus1.f, bus1.g}), 32'(7'b1000111));
    check("wr_slot_com", 32'(bus1.COM), 32'(8'hDF));
    idle(20);

    // Reset while digit 3 is being driven.
    while (cyc % 32 != 14) idle(1);
    check("pre_reset_drive", 32'(bus1.COM), 32'(8'hF7));
    do_reset();

    // Dark frame after reset; meanwhile out-of-range writes to the 6-digit instance.
    bus2.WR_EN = 1'b1; bus2.WR_ADDR = 3'd7; bus2.WR_DATA = 5'h08;
    idle(1);
    bus2.WR_ADDR = 3'd6;
    idle(1);
    bus2.WR_EN = 1'b0;
    for (int i = 0; i < 26; i++) begin
      idle(1);
      check("bad_addr_com", 32'(bus2.COM), 32'(6'h3F));
      check("bad_addr_seg", 32'({bus2.a, bus2.b, bus2.c, bus2.d, bus2.e, bus2.f, bus2.g}), 32'(0));
    end
    idle(6);

    // Valid write on the 6-digit instance shows up in digit 0's slot.
    bus2.WR_EN = 1'b1; bus2.WR_ADDR = 3'd0; bus2.WR_DATA = 5'h01;
    idle(1);
    bus2.WR_EN = 1'b0;
    while (cyc % 24 != 2) idle(1);
    check("dut2_digit0_com", 32'(bus2.COM), 32'(6'h3E));
    check("dut2_digit0_seg", 32'({bus2.a, bus2.b, bus2.c, bus2.d, bus2.e, bus2.f, bus2.g}), 32'(7'b0110000));

    // Leading-zero pattern: digits 7..0 = 0,0,0,0,0,1,0,0.
    for (int i = 0; i < ND; i++) step(1'b1, i, (i == 2) ? 5'h01 : 5'h00);
    idle(36);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/seg_scan_mux.md
# seg_scan_mux

Multiplexed N-digit 7-segment display driver for the piano front panel. It is the parametrised successor of the single-digit 2-bit segment decoder. It holds one 4-bit hex value plus a blank flag per digit, decodes the values to active-high segments a–g, and time-multiplexes them over an active-low common bus COM. A digit whose segments are all off keeps its COM line deasserted. Higher-level logic (note/octave display) writes digit registers through a simple write port.

## Interface
Parameters:
- DIGITS, 8, number of digits / COM lines (2..16)
- SCAN_DIV, 1000, clock cycles per digit slot (≥ 4)
- AW, $clog2(DIGITS), digit address width (derived, not overridden)

Ports (one clock; reset is asynchronous and active-high):
- CLK  in  1  system clock, all state on rising edge
- RST  in  1  asynchronous active-high reset
- WR_EN  in  1  write strobe, sampled on rising CLK
- WR_ADDR  in  AW  digit index; 0 = rightmost / least significant
- WR_DATA  in  5  {blank, hex[3:0]}; blank=1 forces the digit dark
- a,b,c,d,e,f,g  out  1 each  segment drives, active high, registered
- COM  out  DIGITS  digit enables, active low, one-hot-low or all-high, registered
- SCAN_IDX  out  AW  index of digit currently in its slot, for debug/verification

## Operation
- Register file: DIGITS × 5 bits. Reset value {1,0000}, i.e. blank. On WR_EN=1 with WR_ADDR < DIGITS, the entry is written at the clock edge. WR_ADDR ≥ DIGITS is ignored.
- Prescaler: counts 0..SCAN_DIV-1 and wraps. On terminal count (SCAN_DIV-1), SCAN_IDX advances and wraps DIGITS-1 → 0.
- Slot phases:
  - DEAD: prescaler == 0. COM all 1 and segments all 0 (anti-ghosting).
  - DRIVE: prescaler 1..SCAN_DIV-1. Segments = decode(entry[SCAN_IDX]). COM[SCAN_IDX] = 0 only if at least one segment is 1; all other COM bits = 1.
- Decode (hex → abcdefg):
  - 0 → 1111110, 1 → 0110000, 2 → 1101101, 3 → 1111001
  - 4 → 0110011, 5 → 1011011, 6 → 1011111, 7 → 1110000
  - 8 → 1111111, 9 → 1111011, A → 1110111, b → 0011111
  - C → 1001110, d → 0111101, E → 1001111, F → 1000111
  - blank=1 → 0000000
- Simultaneous events:
  - A write and a scan advance in the same cycle both take effect.
  - A write to the digit being driven is visible on the outputs in the next registered update.
- Reset mid-operation: all state returns to reset values immediately, regardless of phase.

## Timing
- Reset values:
  - a..g = 0, COM = all 1s, SCAN_IDX = 0, prescaler = 0
  - All register-file entries blank
- Write latency: write edge N → entry updated at N. If that digit is in DRIVE, outputs reflect it after edge N+1.
- Slot length is exactly SCAN_DIV cycles: 1 DEAD cycle followed by SCAN_DIV-1 DRIVE cycles. Full frame = DIGITS × SCAN_DIV cycles.
- Outputs are derived combinationally from prescaler/SCAN_IDX, then registered. They lag internal state by one cycle. The first DRIVE output after reset appears 2 cycles after RST deasserts.
- COM never has more than one bit low in any cycle.

## Configuration
- SEG_LZB_EN defined: leading-zero blanking is enabled.
  - Digit i (i ≥ 1) is treated as blank when its value is 0 and every digit j > i is 0 or blank.
  - Digit 0 is never suppressed by this rule.
  - Suppressed digits show segments 0 and COM bit high.
- SEG_LZB_EN undefined: zeros always display as "0". No LZB logic is synthesised.

## Test plan
- Reset: assert RST mid-DRIVE on digit 3 → same cycle, COM=FF, a..g=0, SCAN_IDX=0. After release, all digits remain dark for a full frame.
- Scan order: DIGITS=8, SCAN_DIV=4, write digits 0..7 = 0..7 →
  - COM sequence per slot: FF, FE, FE, FE, FF, FD, ...
  - Digit 7's slot drives 1110000.
  - Wrap back to digit 0 after 32 cycles.
- Auto-COM blank: write digit 2 = {1,x} → during slot 2, COM = FF and segments = 0; all other digits unaffected.
- Write during slot: in digit 5's DRIVE, write 5 ← 8 then 5 ← F → outputs go 1111111, then 1000111 one cycle later; no glitch on other COM bits.
- LZB (SEG_LZB_EN): digits 7..0 = 0,0,0,0,0,1,0,0 →
  - Digits 7–3 are dark (COM high).
  - Digits 2, 1, 0 show 1, 0, 0.
  - Without the macro, all eight digits show their values.
- Invalid address: DIGITS=6, WR_ADDR=7, WR_EN=1 → no entry changes; frame is identical before and after.
